// File: rtl/line_window.sv
// Streaming 3x3 neighbourhood generator: buffers two raster lines and presents the
// eight neighbours of each interior pixel with a one-cycle valid strobe.
module line_window #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pix,
  output logic [PIX_W-1:0] pix_0,
  output logic [PIX_W-1:0] pix_1,
  output logic [PIX_W-1:0] pix_2,
  output logic [PIX_W-1:0] pix_3,
  output logic [PIX_W-1:0] pix_5,
  output logic [PIX_W-1:0] pix_6,
  output logic [PIX_W-1:0] pix_7,
  output logic [PIX_W-1:0] pix_8,
  output logic             out_valid,
  output logic             out_eof,
  output logic             state_dbg
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic {SYNC = 1'b0, ACTIVE = 1'b1} state_t;

  // Handshake: a pixel is taken on every rising edge where in_valid is high (no
  // backpressure); out_valid is a one-cycle strobe with the window held until the
  // next accepted pixel.
  state_t           state;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [PIX_W-1:0] la [IMG_W];
  logic [PIX_W-1:0] lb [IMG_W];
  logic [PIX_W-1:0] mid_1;
  logic             accepted;
  logic [CW-1:0]    cur_col;
  logic [RW-1:0]    cur_row;
  logic [PIX_W-1:0] la_rd;
  logic [PIX_W-1:0] lb_rd;

  // A start-of-frame pixel is always position (0,0), whatever the counters say.
  always_comb begin
    accepted = in_valid && (in_sof || state == ACTIVE);
    cur_col  = in_sof ? '0 : col;
    cur_row  = in_sof ? '0 : row;
    la_rd    = la[cur_col];
    lb_rd    = lb[cur_col];
  end

  assign state_dbg = (state == ACTIVE);

  // Line buffers carry no reset; the row >= 2 gate keeps stale data off the outputs.
  always_ff @(posedge clk) begin
    if (accepted) begin
      la[cur_col] <= in_pix;
      lb[cur_col] <= la_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SYNC;
      col       <= '0;
      row       <= '0;
      pix_0     <= '0;
      pix_1     <= '0;
      pix_2     <= '0;
      pix_3     <= '0;
      mid_1     <= '0;
      pix_5     <= '0;
      pix_6     <= '0;
      pix_7     <= '0;
      pix_8     <= '0;
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      if (accepted) begin
        state <= ACTIVE;
        if (cur_col == COL_LAST) begin
          col <= '0;
          row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
        // Window shifts left; the new right column is (row-2, row-1, row).
        pix_0 <= pix_1;
        pix_1 <= pix_2;
        pix_2 <= lb_rd;
        pix_3 <= mid_1;
        mid_1 <= pix_5;
        pix_5 <= la_rd;
        pix_6 <= pix_7;
        pix_7 <= pix_8;
        pix_8 <= in_pix;
        if (cur_row >= ROW_TWO && cur_col >= COL_TWO) begin
          out_valid <= 1'b1;
          out_eof   <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end
      end
    end
  end

endmodule

// File: tb/tb_line_window.sv
// Self-checking bench for line_window on a 4x4 image: a frame-array reference model
// predicts every window, strobe and end-of-frame flag.
module tb_line_window;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_pix;
  logic [7:0] pix_0, pix_1, pix_2, pix_3, pix_5, pix_6, pix_7, pix_8;
  logic       out_valid;
  logic       out_eof;
  logic       state_dbg;

  line_window #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .pix_0(pix_0), .pix_1(pix_1), .pix_2(pix_2), .pix_3(pix_3), .pix_5(pix_5),
    .pix_6(pix_6), .pix_7(pix_7), .pix_8(pix_8),
    .out_valid(out_valid), .out_eof(out_eof), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // scoreboard and reference model
  logic [64:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_strobe;
  int          n_eof;
  logic [63:0] first_win;
  logic [7:0]  eof_pix8;
  bit          m_active;
  int          m_r, m_c;
  logic [7:0]  frame [H][W];
  logic [63:0] last_win;
  bit          have_last;

  function automatic logic [64:0] dut_win();
    return {pix_0, pix_1, pix_2, pix_3, pix_5, pix_6, pix_7, pix_8, out_eof};
  endfunction

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active  = 1'b0;
    m_r       = 0;
    m_c       = 0;
    last_win  = '0;
    have_last = 1'b1;
    exp_q.delete();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pix   = '0;
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {dut_win(), out_valid, state_dbg}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  // One clock of stimulus, then compare the DUT against the model after the edge.
  task automatic step(input bit v, input bit s, input logic [7:0] p);
    bit          acc;
    bit          ev;
    int          r, c;
    logic [64:0] e;
    in_valid = v;
    in_sof   = s;
    in_pix   = p;
    acc = v && (m_active || s);
    ev  = 1'b0;
    if (acc) begin
      if (s) begin
        m_active = 1'b1;
        m_r = 0;
        m_c = 0;
      end
      r = m_r;
      c = m_c;
      frame[r][c] = p;
      if (r >= 2 && c >= 2) begin
        ev = 1'b1;
        exp_q.push_back({frame[r-2][c-2], frame[r-2][c-1], frame[r-2][c],
                         frame[r-1][c-2], frame[r-1][c],
                         frame[r][c-2], frame[r][c-1], frame[r][c],
                         (r == H - 1) && (c == W - 1)});
      end
      m_c++;
      if (m_c == W) begin
        m_c = 0;
        m_r = (m_r == H - 1) ? 0 : m_r + 1;
      end
    end
    @(posedge clk);
    #1;
    check("state", state_dbg, m_active);
    check("out_valid", out_valid, ev);
    if (out_valid) begin
      if (n_strobe == 0) first_win = dut_win() >> 1;
      n_strobe++;
    end
    if (out_eof) begin
      n_eof++;
      eof_pix8 = pix_8;
    end
    if (ev) begin
      e = exp_q.pop_front();
      check("window", dut_win(), e);
      last_win  = e[64:1];
      have_last = 1'b1;
    end else begin
      if (acc) have_last = 1'b0;
      if (have_last) check("hold", dut_win(), {last_win, 1'b0});
      else check("eof_idle", out_eof, 1'b0);
    end
  endtask

  // driver: gap 0 = back-to-back, 1 = one idle per pixel, 2 = random 0..2 idles
  task automatic send_frame(input int base, input bit rnd, input int gap,
                            input int n_pix, input bit sof_en);
    logic [7:0] pv;
    int         k;
    for (int i = 0; i < n_pix; i++) begin
      pv = rnd ? 8'($urandom_range(0, 255)) : 8'(base + 16 * (i / W) + (i % W));
      step(1'b1, sof_en && (i == 0), pv);
      k = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (k) step(1'b0, 1'(($urandom_range(0, 1))), 8'($urandom_range(0, 255)));
    end
  endtask

  task automatic clear_counts();
    n_strobe  = 0;
    n_eof     = 0;
    first_win = '0;
    eof_pix8  = '0;
  endtask

  initial begin
    rst = 1'b1;
    model_reset();

    // back-to-back frame
    do_reset();
    clear_counts();
    send_frame(0, 1'b0, 0, W * H, 1'b1);
    check("s1_strobes", n_strobe, 4);
    check("s1_eofs", n_eof, 1);
    check("s1_first_window", first_win, 64'h0001021012202122);
    check("s1_eof_pix8", eof_pix8, 8'h33);

    // one idle cycle after every pixel
    clear_counts();
    send_frame(0, 1'b0, 1, W * H, 1'b1);
    check("s2_strobes", n_strobe, 4);
    check("s2_first_window", first_win, 64'h0001021012202122);

    // pixels before any start-of-frame are discarded
    do_reset();
    clear_counts();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    check("s3_pre_sof_strobes", n_strobe, 0);
    send_frame(0, 1'b0, 0, W * H, 1'b1);
    check("s3_strobes", n_strobe, 4);
    check("s3_first_window", first_win, 64'h0001021012202122);

    // reset after pixel (2,1)
    send_frame(0, 1'b0, 0, 10, 1'b1);
    do_reset();
    clear_counts();
    send_frame(0, 1'b0, 0, W * H, 1'b1);
    check("s4_strobes", n_strobe, 4);
    check("s4_first_window", first_win, 64'h0001021012202122);

    // start-of-frame injected at (1,3)
    clear_counts();
    send_frame(0, 1'b0, 0, 7, 1'b1);
    send_frame(0, 1'b0, 0, W * H, 1'b1);
    check("s5_strobes", n_strobe, 4);
    check("s5_first_window", first_win, 64'h0001021012202122);

    // two consecutive frames with distinct values
    clear_counts();
    send_frame(0, 1'b0, 0, W * H, 1'b1);
    send_frame(8'h80, 1'b0, 0, W * H, 1'b1);
    check("s6_strobes", n_strobe, 8);
    check("s6_eofs", n_eof, 2);
    check("s6_eof_pix8", eof_pix8, 8'hb3);

    // random pixels and gaps; the middle frame omits its start-of-frame flag
    clear_counts();
    send_frame(0, 1'b1, 2, W * H, 1'b1);
    send_frame(0, 1'b1, 2, W * H, 1'b0);
    send_frame(0, 1'b1, 2, W * H, 1'b1);
    check("s7_strobes", n_strobe, 12);
    check("s7_eofs", n_eof, 3);
    check("s7_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_window.md
# line_window

Streaming 3x3 neighbourhood generator that sits directly upstream of the Sobel stage. It accepts a raster-order 8-bit greyscale pixel stream and buffers the two previous image lines. For every input pixel whose full 3x3 neighbourhood lies inside the image, it presents the eight neighbours of the centre pixel (pix_0..pix_3, pix_5..pix_8; the centre is not needed by the Sobel kernel) with a one-cycle valid strobe. It replaces the free-running image source feeding sobel's pix_* inputs.

## Interface
- IMG_W, 160, pixels per line (>= 3)
- IMG_H, 120, lines per frame (>= 3)
- PIX_W, 8, bits per pixel
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input pixel present this cycle; no backpressure
- in_sof  in  1  qualifies in_valid; marks pixel (row 0, col 0) of a frame
- in_pix  in  PIX_W  input pixel
- pix_0, pix_1, pix_2  out  PIX_W  top row of window, left to right
- pix_3, pix_5  out  PIX_W  middle row, left and right
- pix_6, pix_7, pix_8  out  PIX_W  bottom row, left to right
- out_valid  out  1  window outputs valid this cycle (one-cycle strobe)
- out_eof  out  1  coincides with out_valid for the last window of the frame

## Operation
- States: SYNC (reset state) and ACTIVE.
  - SYNC: accepted pixels without in_sof are discarded (no counter or buffer change).
  - in_valid & in_sof in any state -> ACTIVE. That pixel is (0,0): col and row are forced to 0.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the current accepted pixel.
  - After each accepted pixel in ACTIVE, col increments.
  - col wraps from IMG_W-1 to 0 and row increments.
  - After (IMG_H-1, IMG_W-1), row and col return to 0; state stays ACTIVE.
  - The next frame's first pixel is expected to carry in_sof. A missing in_sof is tolerated; position still wraps.
- Line buffers LA (row r-1) and LB (row r-2), IMG_W x PIX_W each, read asynchronously at address col. On accepted pixel p at (r,c):
  - a = LA[c], b = LB[c].
  - LA[c] <= p, LB[c] <= a.
  - Window shift register (3 columns x 3 rows) shifts left. New right column: top = b, middle = a, bottom = p.
- Output mapping after shift: pix_0/1/2 = top row cols c-2, c-1, c; pix_3/pix_5 = middle row cols c-2, c; pix_6/7/8 = bottom row cols c-2, c-1, c. The window is centred at (r-1, c-1).
- out_valid <= accepted & ACTIVE & r >= 2 & c >= 2. Windows spanning a line wrap are never flagged valid.
- out_eof <= out_valid condition & r = IMG_H-1 & c = IMG_W-1.
- Exactly (IMG_W-2)*(IMG_H-2) valid windows per full frame.
- Line buffers are not reset. Stale contents are never exposed because of the r >= 2 gate.

## Timing
- Latency: pixel accepted at edge k appears in pix_8 with out_valid after edge k; the window is held until the next accepted pixel.
- Throughput: one pixel per clock. in_valid may drop at any cycle; all state holds and out_valid = 0 during gaps.
- Reset (async assert, sync release): state = SYNC, col = row = 0, window registers = 0, all pix_* = 0, out_valid = out_eof = 0.
- Reset mid-frame: partial frame abandoned; block waits for the next in_sof.
- in_sof mid-frame: position resyncs to (0,0) on that pixel; no valid output until (2,2) of the new frame.
- in_sof without in_valid: ignored.

## Test plan
- IMG_W=4, IMG_H=4, in_pix = 16*r + c, one frame back-to-back. Expected: after pixel (2,2), out_valid=1 with pix_0..8 = 00,01,02,10,12,20,21,22. Exactly 4 strobes total; out_eof only with window pix_8=0x33.
- Same frame with in_valid deasserted every other cycle. Expected: identical window sequence; out_valid never asserted in gap cycles.
- Pixels sent before any in_sof after reset. Expected: no out_valid; the first frame after in_sof matches the first scenario.
- Reset asserted after pixel (2,1), then a full frame with in_sof. Expected: all outputs 0 during reset; 4 correct windows follow.
- in_sof injected at (1,3), then a full frame. Expected: resync; the first valid window is again 00..22.
- Two consecutive frames with values 0x80 + 16*r + c in frame 2. Expected: frame-2 windows contain no frame-1 values; 8 strobes total, 2 out_eof pulses.
